// File: rtl/a51_pkg.sv
// A5/1 shared constants: LFSR geometry, load lengths and the decryptor state encoding.
// Geometry follows the GSM A5/1 definition so the core is reusable on the transmit side.
package a51_pkg;

    localparam int R1_LEN = 19;
    localparam int R2_LEN = 22;
    localparam int R3_LEN = 23;

    localparam logic [R1_LEN-1:0] R1_TAPS = 19'h07_2000;   // bits 18,17,16,13
    localparam logic [R2_LEN-1:0] R2_TAPS = 22'h30_0000;   // bits 21,20
    localparam logic [R3_LEN-1:0] R3_TAPS = 23'h70_0080;   // bits 22,21,20,7

    localparam int R1_CLK = 8;
    localparam int R2_CLK = 10;
    localparam int R3_CLK = 10;

    localparam int KEY_BITS   = 64;
    localparam int FRAME_BITS = 22;

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEY,
        S_FRAME,
        S_MIX,
        S_SKIP,
        S_RUN,
        S_FLUSH
    } state_t;

endpackage

// File: rtl/a51_core.sv
// A5/1 register bank: unconditional or majority stepping with optional bit-0 injection.
// o_ks is the keystream bit the next step would produce, so callers can use it in the same cycle.
module a51_core
    import a51_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_load,
    input  logic i_inj,
    input  logic i_step,
    input  logic i_maj,
    output logic o_ks
);

    logic [R1_LEN-1:0] r_r1;
    logic [R2_LEN-1:0] r_r2;
    logic [R3_LEN-1:0] r_r3;

    logic [R1_LEN-1:0] w_r1_sh, w_r1_nx;
    logic [R2_LEN-1:0] w_r2_sh, w_r2_nx;
    logic [R3_LEN-1:0] w_r3_sh, w_r3_nx;
    logic              w_maj_bit;
    logic              w_c1, w_c2, w_c3;
    logic              w_inj;

    assign w_r1_sh = {r_r1[R1_LEN-2:0], ^(r_r1 & R1_TAPS)};
    assign w_r2_sh = {r_r2[R2_LEN-2:0], ^(r_r2 & R2_TAPS)};
    assign w_r3_sh = {r_r3[R3_LEN-2:0], ^(r_r3 & R3_TAPS)};

    assign w_maj_bit = (r_r1[R1_CLK] & r_r2[R2_CLK]) |
                       (r_r1[R1_CLK] & r_r3[R3_CLK]) |
                       (r_r2[R2_CLK] & r_r3[R3_CLK]);

    // Without majority mode every register steps (key/frame loading).
    assign w_c1 = !i_maj || (r_r1[R1_CLK] == w_maj_bit);
    assign w_c2 = !i_maj || (r_r2[R2_CLK] == w_maj_bit);
    assign w_c3 = !i_maj || (r_r3[R3_CLK] == w_maj_bit);

    assign w_inj = i_load & i_inj;

    assign w_r1_nx = w_c1 ? (w_r1_sh ^ {{(R1_LEN-1){1'b0}}, w_inj}) : r_r1;
    assign w_r2_nx = w_c2 ? (w_r2_sh ^ {{(R2_LEN-1){1'b0}}, w_inj}) : r_r2;
    assign w_r3_nx = w_c3 ? (w_r3_sh ^ {{(R3_LEN-1){1'b0}}, w_inj}) : r_r3;

    assign o_ks = w_r1_nx[R1_LEN-1] ^ w_r2_nx[R2_LEN-1] ^ w_r3_nx[R3_LEN-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_r1 <= '0;
            r_r2 <= '0;
            r_r3 <= '0;
        end else if (i_clear) begin
            r_r1 <= '0;
            r_r2 <= '0;
            r_r3 <= '0;
        end else if (i_step) begin
            r_r1 <= w_r1_nx;
            r_r2 <= w_r2_nx;
            r_r3 <= w_r3_nx;
        end
    end

endmodule

// File: rtl/a51_rx_decryptor.sv
// Receive-side A5/1 burst decryptor: key/frame set-up, warm-up, optional skip, then one burst.
// Plaintext one cycle after each ciphertext transfer; keystream only advances on a transfer.
module a51_rx_decryptor
    import a51_pkg::*;
#(
    parameter int BURST_BITS = 114,
    parameter int MIX_CLOCKS = 100,
    parameter int ROLE       = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] key,
    input  logic [21:0] frame,
    output logic        busy,
    input  logic        c_valid,
    output logic        c_ready,
    input  logic        c_bit,
    output logic        p_valid,
    input  logic        p_ready,
    output logic        p_bit,
    output logic        done
);

    state_t      r_state, w_nxt;
    logic [7:0]  r_cnt;
    logic [63:0] r_key;
    logic [21:0] r_frame;
    logic        r_p_valid;
    logic        r_p_bit;

    logic w_clear, w_load, w_inj, w_step, w_maj, w_ks, w_xfer, w_done;

    assign c_ready = (r_state == S_RUN) && (!r_p_valid || p_ready) &&
                     (r_cnt < 8'(BURST_BITS));
    assign w_xfer  = c_valid && c_ready;

    always_comb begin
        w_nxt   = r_state;
        w_clear = 1'b0;
        w_load  = 1'b0;
        w_inj   = 1'b0;
        w_step  = 1'b0;
        w_maj   = 1'b0;
        w_done  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_clear = 1'b1;
                    w_nxt   = S_KEY;
                end
            end
            S_KEY: begin
                w_step = 1'b1;
                w_load = 1'b1;
                w_inj  = r_key[r_cnt[5:0]];
                if (r_cnt == 8'(KEY_BITS - 1)) w_nxt = S_FRAME;
            end
            S_FRAME: begin
                w_step = 1'b1;
                w_load = 1'b1;
                w_inj  = r_frame[r_cnt[4:0]];
                if (r_cnt == 8'(FRAME_BITS - 1)) w_nxt = S_MIX;
            end
            S_MIX: begin
                w_step = 1'b1;
                w_maj  = 1'b1;
                if (r_cnt == 8'(MIX_CLOCKS - 1)) w_nxt = (ROLE == 1) ? S_SKIP : S_RUN;
            end
            S_SKIP: begin
                w_step = 1'b1;
                w_maj  = 1'b1;
                if (r_cnt == 8'(BURST_BITS - 1)) w_nxt = S_RUN;
            end
            S_RUN: begin
                w_maj  = 1'b1;
                w_step = w_xfer;
                if (w_xfer && (r_cnt == 8'(BURST_BITS - 1))) w_nxt = S_FLUSH;
            end
            S_FLUSH: begin
                // Done is raised only once the last plaintext bit has left.
                if (!r_p_valid) begin
                    w_done = 1'b1;
                    w_nxt  = S_IDLE;
                end
            end
            default: w_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_key     <= '0;
            r_frame   <= '0;
            r_p_valid <= 1'b0;
            r_p_bit   <= 1'b0;
        end else begin
            r_state <= w_nxt;
            if (w_nxt != r_state) r_cnt <= '0;
            else if (w_step)      r_cnt <= r_cnt + 8'd1;
            if ((r_state == S_IDLE) && start) begin
                r_key   <= key;
                r_frame <= frame;
            end
            if (w_xfer) begin
                r_p_valid <= 1'b1;
                r_p_bit   <= c_bit ^ w_ks;
            end else if (p_ready) begin
                r_p_valid <= 1'b0;
            end
        end
    end

    a51_core u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_clear),
        .i_load  (w_load),
        .i_inj   (w_inj),
        .i_step  (w_step),
        .i_maj   (w_maj),
        .o_ks    (w_ks)
    );

    assign busy    = (r_state != S_IDLE);
    assign p_valid = r_p_valid;
    assign p_bit   = r_p_bit;
    assign done    = w_done;

endmodule
